// File: rtl/keypad_timer_entry_if.sv
// Keypad/timer bus between the keypad front-end and its environment.
// slave  : seen by keypad_timer_entry (keypad, mode and clear in; code, entry, strobes out)
// master : seen by whoever drives the keypad and consumes the entry/tick outputs
interface keypad_timer_entry_if #(
  parameter int unsigned DIGITS = 4
);
  logic [9:0]          teclado;
  logic                enablen;
  logic                clear;
  logic [3:0]          D;
  logic [4*DIGITS-1:0] digits;
  logic                loadn;
  logic                key_stb;
  logic                tick;
  logic                pgt_1Hz;

  modport master (
    output teclado, enablen, clear,
    input  D, digits, loadn, key_stb, tick, pgt_1Hz
  );

  modport slave (
    input  teclado, enablen, clear,
    output D, digits, loadn, key_stb, tick, pgt_1Hz
  );
endinterface

// File: rtl/keypad_timer_entry.sv
// Keypad front-end and count time-base for the microwave timer path.
// Synchronises and priority-encodes a 10-key keypad, debounces it, shifts
// accepted BCD digits into an entry register, and divides the clock into a
// count tick. pgt_1Hz carries key strobes in entry mode, ticks in count mode.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous active-high reset
//   bus     - keypad_timer_entry_if.slave:
//             teclado (10 keys, async), enablen (0 entry / 1 count), clear,
//             D (last key), digits (entry register, newest in [3:0]),
//             loadn (low while accepted key held), key_stb, tick,
//             pgt_1Hz (combinational mux of tick / key_stb)
module keypad_timer_entry #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV      = 100,
  parameter int unsigned DEBOUNCE = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  keypad_timer_entry_if.slave         bus
);

  localparam int unsigned DIG_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned DIV_W = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, CHECK, HELD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         latched;
  logic [9:0]         sync1;
  logic [9:0]         sync2;
  logic [3:0]         key_code;
  logic               key_any;
  logic [3:0]         last_code;
  logic [DIG_W-1:0]   entry;
  logic               hold_n;
  logic               strobe;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick_r;

  // Two-flop synchroniser for the asynchronous keypad
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.teclado;
      sync2 <= sync1;
    end
  end

  // Priority encoder: ascending scan so the highest pressed key wins
  always_comb begin
    key_code = 4'd0;
    key_any  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sync2[k]) begin
        key_code = 4'(k);
        key_any  = 1'b1;
      end
    end
  end

  // Debounce FSM with registered outputs; the cast keeps the low DIG_W bits,
  // dropping the oldest digit and working for DIGITS=1 as well
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      latched   <= '0;
      last_code <= '0;
      entry     <= '0;
      hold_n    <= 1'b1;
      strobe    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (bus.enablen) begin
        state  <= IDLE;
        hold_n <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (key_any) begin
              latched <= key_code;
              cnt     <= CNT_W'(1);
              if (DEBOUNCE == 1) begin
                state     <= HELD;
                strobe    <= 1'b1;
                last_code <= key_code;
                entry     <= DIG_W'({entry, key_code});
                hold_n    <= 1'b0;
              end else begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (!key_any) begin
              state <= IDLE;
            end else if (key_code != latched) begin
              latched <= key_code;
              cnt     <= CNT_W'(1);
            end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
              state     <= HELD;
              strobe    <= 1'b1;
              last_code <= key_code;
              entry     <= DIG_W'({entry, key_code});
              hold_n    <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!key_any) begin
              state  <= IDLE;
              hold_n <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            hold_n <= 1'b1;
          end
        endcase
      end
      // Clear overrides a same-edge shift; D and the strobe still update
      if (bus.clear) begin
        entry <= '0;
      end
    end
  end

  // Count-mode divider, held at zero in entry mode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick_r  <= 1'b0;
    end else if (!bus.enablen) begin
      div_cnt <= '0;
      tick_r  <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick_r  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick_r  <= 1'b0;
    end
  end

  assign bus.D       = last_code;
  assign bus.digits  = entry;
  assign bus.loadn   = hold_n;
  assign bus.key_stb = strobe;
  assign bus.tick    = tick_r;
  assign bus.pgt_1Hz = bus.enablen ? tick_r : strobe;

endmodule

// File: doc/keypad_timer_entry.md
# keypad_timer_entry

Parametrised keypad front-end and time-base for the microwave timer path. It debounces a 10-key keypad, priority-encodes it to BCD, and shifts accepted digits into a DIGITS-wide BCD entry register. It also divides the system clock into a count tick. The `pgt_1Hz` output carries key strobes in entry mode and divider ticks in count mode, feeding the downstream timer counters.

## Interface
- `DIGITS`, default 4: number of BCD digits held in the entry register (≥1).
- `DIV`, default 100: clock cycles per count tick (≥2).
- `DEBOUNCE`, default 7: consecutive identical FSM samples required to accept a key (≥1).

- `clock` input 1: single system clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `teclado` input 10: keypad, bit k high = key k pressed; asynchronous to `clock`.
- `enablen` input 1: mode select. 0 = entry mode (keys accepted, divider held). 1 = count mode (keys ignored, divider runs).
- `clear` input 1: synchronous, active-high; zeroes `digits`.
- `D` output 4: BCD code of the last accepted key.
- `digits` output 4*DIGITS: entry register. The newest digit is in bits [3:0].
- `loadn` output 1: active-low; low while an accepted key is still held.
- `key_stb` output 1: one-cycle pulse per accepted key.
- `tick` output 1: one-cycle pulse, once every DIV cycles in count mode.
- `pgt_1Hz` output 1: combinational. Equals `tick` when `enablen`=1, else `key_stb`.

## Operation
- **Synchroniser:** `teclado` passes through a 2-flop synchroniser. The synchronised vector is priority-encoded with the highest index winning, producing `code` and `any`.
- **Debounce FSM states:** IDLE, CHECK, HELD. The FSM keeps a stable-sample counter of width $clog2(DEBOUNCE+1) and a latched code.
  - IDLE: if `any` and `enablen`=0, latch `code` and set cnt=1. If DEBOUNCE=1, accept immediately (go to HELD); otherwise go to CHECK.
  - CHECK: if `!any`, go to IDLE. If `code` ≠ latched, re-latch and set cnt=1. If `code` = latched, increment cnt; when the increment reaches DEBOUNCE, accept and go to HELD.
  - Accept action: `key_stb`<=1 for one cycle, `D`<=code, `digits`<={digits[4*DIGITS-5:0], code}.
  - HELD: stay while `any`. On the first edge with `!any`, go to IDLE. No further strobes occur until release.
  - `enablen`=1 in any state forces IDLE at the next edge, with no strobe.
- **Overflow:** when the entry register is full, the oldest (most significant) digit is discarded. For DIGITS=1, `digits` simply follows `D`.
- **`clear`:** sets `digits` to 0. If `clear` and an accept occur on the same edge, `clear` wins and the digit is dropped from `digits`, but `D` still updates and `key_stb` still pulses.
- **Divider:** counter of width $clog2(DIV), held at 0 while `enablen`=0. In count mode it increments each edge. When the count is DIV-1, the counter wraps to 0 and `tick`<=1 for one cycle.
- **Reset values:** D=0, digits=0, loadn=1, key_stb=0, tick=0, FSM=IDLE, divider=0. Consequently `pgt_1Hz`=0.

## Timing
- **Key acceptance latency:** key asserted before edge 1 and held. The synchroniser has `code` valid after edge 2, and the first FSM sample is at edge 3. `key_stb` is high in the cycle after edge DEBOUNCE+2 (edge 9 for the default). `loadn` falls at that same edge.
- **Release latency:** key released before edge r. `loadn` rises after edge r+2.
- **Tick latency:** `enablen` rises before edge 1. The first `tick` is high after edge DIV, with period DIV thereafter. When `enablen` falls, the counter and `tick` clear at the next edge.
- **`pgt_1Hz` glitches:** `pgt_1Hz` may glitch combinationally when `enablen` toggles. Downstream logic samples it on `clock` only.
- **Reset mid-operation:** asserting `reset` mid-debounce or mid-hold aborts immediately, with no strobe. After release of reset, a still-held key needs the full DEBOUNCE+2 latency.

## Test plan
- **Reset:** assert `reset` with keys pressed and `enablen`=1. Required: D=0, digits=0, loadn=1, key_stb=0, tick=0, pgt_1Hz=0 throughout.
- **Single key** (defaults, `enablen`=0): hold key 5 for 15 cycles. Required: exactly one `key_stb`/`pgt_1Hz` pulse after edge 9, D=5, digits=16'h0005, and `loadn` low from edge 9 until 3 edges after release.
- **Bounce:** hold key 3 for 4 cycles, release for 1 cycle, then hold for 10 cycles. Required: no strobe during the first burst, then a single strobe 9 edges after the final press begins, D=3.
- **Multi-key and shift:** press keys 2 and 8 together, then in sequence 1, 2, 3, 4 (each with release). Required: D=8, and finally digits=16'h1234. Then a sixth key 7 gives digits=16'h2347.
- **Count mode:** `enablen`=1 for 350 cycles while key 9 is held. Required: `tick` and `pgt_1Hz` high after edges 100, 200 and 300 only. No `key_stb`, `loadn`=1, digits unchanged.
- **Corners:** `clear` coincident with an accept gives digits=0, D=new code, `key_stb` pulses. `enablen` rising during CHECK gives no strobe. `reset` during HELD forces `loadn`=1 immediately.
